move_sequencer: RTL and testbench
=================================

// Module: move_sequencer
// PURPOSE
//  Queues board-move commands from the host link and issues them one at a time to motor_main:
//  one-cycle request pulses (direction[7:0], scan_offset_move, scan_move, horizontal_offset, reset),
//  then waits for the matching done. Owns the electromagnet enable, including its settle time,
//  and a per-move timeout. Sits between the host command decoder and motor_main.
// PARAMETERS
//  FIFO_DEPTH   16        command queue entries (power of 2, >=2)
//  SETTLE_CYC   50000     clk cycles held after any magnet_en change before the move is issued
//  TIMEOUT_CYC  24'hFFFFFF max clk cycles in WAIT_DONE before fault
// PORTS
//  clk               in   1  system clock
//  reset_n           in   1  reset, asynchronous, active-low
//  cmd_valid         in   1  host offers a command
//  cmd_ready         out  1  queue not full; transfer when valid&&ready
//  cmd_code          in   4  0..7 N,NE,E,SE,S,SW,W,NW; 8 HOME; 9 HOFF; 10 SCAN_OFS; 11 SCAN
//  cmd_magnet        in   1  magnet state required during this move
//  clear_fault       in   1  one-cycle pulse; leaves FAULT
//  direction         out  8  one-hot move pulse to motor_main (bit = cmd_code)
//  scan_offset_move  out  1  pulse, code 10
//  scan_move         out  1  pulse, code 11
//  horizontal_offset out  1  pulse, code 9
//  home              out  1  pulse, code 8 (drives motor_main reset)
//  movement_done     in   1  from motor_main (codes 0..7, 10, 11)
//  reset_done        in   1  from motor_main (code 8)
//  offset_done       in   1  from motor_main (code 9)
//  magnet_en         out  1  electromagnet drive
//  busy              out  1  state != IDLE or queue non-empty
//  fault             out  1  state == FAULT
//  fifo_count        out  $clog2(FIFO_DEPTH)+1  queue occupancy
// BEHAVIOUR
//  Reset: all outputs 0, except cmd_ready=1. Queue empty, state IDLE, counters 0. Reset asserted mid-move
//   aborts at once; magnet_en=0 asynchronously.
//  Queue: push on valid&&ready. Pop in IDLE when non-empty. Push+pop in one cycle leaves count unchanged;
//   full -> cmd_ready=0; push while full is ignored.
//  FSM:
//   IDLE: pop head into cur_code/cur_mag (1 cycle). Code 12..15 -> FAULT.
//    If cur_mag!=magnet_en (HOME forces cur_mag=0): update magnet_en, go to SETTLE; else go to ISSUE.
//   SETTLE: count SETTLE_CYC cycles, then go to ISSUE.
//   ISSUE: exactly one request output high for 1 cycle, then go to WAIT_DONE; timer cleared.
//   WAIT_DONE: watch the done selected by cur_code; high -> WAIT_CLR. Timer reaches TIMEOUT_CYC -> FAULT.
//   WAIT_CLR: wait until the selected done is low, then go to IDLE. This guarantees motor_main has dropped go
//    before the next pulse.
//  Pop-to-pulse latency: 2 cycles without a magnet change, SETTLE_CYC+2 with one.
//  Back-to-back moves have no idle gap beyond WAIT_CLR + pop.
//  FAULT: magnet_en=0, queue flushed, cmd_ready=0, all pulses 0. On clear_fault go to IDLE.
//   clear_fault outside FAULT is ignored.
//  Done inputs not selected by cur_code are ignored. A done already high on entry to WAIT_DONE counts.
//  At most one request output is high in any cycle.
// STRUCTURE
//  defines.v gains: CMD_* code constants, FSM state encodings, SETTLE/TIMEOUT defaults.
//  One sub-module, move_fifo: sync FIFO, 5-bit entries {magnet, code}, count output, async active-low reset.
//  FSM, settle/timeout counter (shared 24-bit) and pulse decode live in move_sequencer.
// TESTING (SETTLE_CYC=4, TIMEOUT_CYC=100, bench models motor_main: done 10 cycles after pulse,
//  clears 2 cycles later)
//  1. Push N(0), mag=0
//     -> direction=8'h01 for exactly 1 cycle, 2 cycles after pop; busy drops after done clears.
//  2. Push E(2) mag=1, then SE(3) mag=1
//     -> magnet_en rises, first pulse 4+2 cycles later; second pulse follows with no settle.
//     direction=8'h04 then 8'h08.
//  3. Push 17 commands with no pop possible (model holds done low)
//     -> cmd_ready=0 at count=16; 17th not stored.
//  4. Model never returns done
//     -> fault=1 at 100 cycles after pulse; magnet_en=0, fifo_count=0.
//     clear_fault -> IDLE, cmd_ready=1.
//  5. HOME (8) while magnet_en=1
//     -> magnet_en=0, settle, home pulse; only reset_done completes it.
//     A movement_done pulse meanwhile is ignored.
//  6. Assert reset_n low during WAIT_DONE
//     -> all outputs 0 immediately (magnet_en async); queue empty after release.

Source files
------------

// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the move sequencer: command codes, FSM states,
// queue entry layout and default timing.
package move_sequencer_pkg;

  localparam logic [3:0] CMD_N        = 4'd0;
  localparam logic [3:0] CMD_NE       = 4'd1;
  localparam logic [3:0] CMD_E        = 4'd2;
  localparam logic [3:0] CMD_SE       = 4'd3;
  localparam logic [3:0] CMD_S        = 4'd4;
  localparam logic [3:0] CMD_SW       = 4'd5;
  localparam logic [3:0] CMD_W        = 4'd6;
  localparam logic [3:0] CMD_NW       = 4'd7;
  localparam logic [3:0] CMD_HOME     = 4'd8;
  localparam logic [3:0] CMD_HOFF     = 4'd9;
  localparam logic [3:0] CMD_SCAN_OFS = 4'd10;
  localparam logic [3:0] CMD_SCAN     = 4'd11;

  localparam int NUM_REQ         = 12;
  localparam int CNT_W           = 24;
  localparam int SETTLE_CYC_DEF  = 50000;
  localparam int TIMEOUT_CYC_DEF = 24'hFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_WAIT_CLR,
    ST_FAULT
  } state_t;

  typedef struct packed {
    logic       magnet;
    logic [3:0] code;
  } cmd_t;

  // Each command completes on exactly one of motor_main's done lines.
  function automatic logic done_sel(input logic [3:0] code,
                                    input logic movement_done,
                                    input logic reset_done,
                                    input logic offset_done);
    if (code == CMD_HOME)
      return reset_done;
    else if (code == CMD_HOFF)
      return offset_done;
    else
      return movement_done;
  endfunction

endpackage

// File: rtl/move_sequencer_fifo.sv
// Synchronous command queue of {magnet, code} entries with occupancy count
// and a flush used when the sequencer faults.
module move_fifo
  import move_sequencer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  cmd_t                       din,
  input  logic                       pop,
  input  logic                       flush,
  output cmd_t                       dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Issues queued board moves to motor_main one at a time, owning the magnet
// enable (with settle delay) and a per-move completion timeout.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_code,
  input  logic                          cmd_magnet,
  input  logic                          clear_fault,
  output logic [7:0]                    direction,
  output logic                          scan_offset_move,
  output logic                          scan_move,
  output logic                          horizontal_offset,
  output logic                          home,
  input  logic                          movement_done,
  input  logic                          reset_done,
  input  logic                          offset_done,
  output logic                          magnet_en,
  output logic                          busy,
  output logic                          fault,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t               state_reg, state_next;
  logic [3:0]           cur_code_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 cnt_run;
  logic                 magnet_reg, magnet_next;
  logic [NUM_REQ-1:0]   pulse_reg, pulse_next;
  logic [NUM_REQ-1:0]   code_onehot;

  cmd_t                 fifo_din, head;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, flush;
  logic                 head_mag;
  logic                 sel_done;

  assign fifo_din = '{magnet: cmd_magnet, code: cmd_code};
  assign push     = cmd_valid && cmd_ready;

  move_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (fifo_din),
    .pop     (pop),
    .flush   (flush),
    .dout    (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // HOME always runs with the magnet released.
  assign head_mag = (head.code == CMD_HOME) ? 1'b0 : head.magnet;
  assign sel_done = done_sel(cur_code_reg, movement_done, reset_done, offset_done);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_decode
      assign code_onehot[gi] = (cur_code_reg == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head.code > CMD_SCAN)
            state_next = ST_FAULT;
          else if (head_mag != magnet_reg)
            state_next = ST_SETTLE;
          else
            state_next = ST_ISSUE;
        end
      end
      ST_SETTLE:    if (cnt_reg == SETTLE_LAST) state_next = ST_ISSUE;
      ST_ISSUE:     state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (sel_done)
          state_next = ST_WAIT_CLR;
        else if (cnt_reg == TIMEOUT_LAST)
          state_next = ST_FAULT;
      end
      ST_WAIT_CLR:  if (!sel_done) state_next = ST_IDLE;
      ST_FAULT:     if (clear_fault) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    magnet_next = magnet_reg;
    pulse_next  = '0;
    cnt_run     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        pop = !fifo_empty;
        if (!fifo_empty)
          magnet_next = head_mag;
      end
      ST_SETTLE:    cnt_run = 1'b1;
      ST_ISSUE:     pulse_next = code_onehot;
      ST_WAIT_DONE: cnt_run = 1'b1;
      default: ;
    endcase
    // Entering or holding FAULT drops the magnet and empties the queue at once.
    flush = (state_next == ST_FAULT);
    if (flush)
      magnet_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_code_reg <= '0;
      cnt_reg      <= '0;
      magnet_reg   <= 1'b0;
      pulse_reg    <= '0;
    end else begin
      if (pop)
        cur_code_reg <= head.code;
      cnt_reg    <= cnt_run ? cnt_reg + 1'b1 : '0;
      magnet_reg <= magnet_next;
      pulse_reg  <= pulse_next;
    end
  end

  assign direction         = pulse_reg[7:0];
  assign home              = pulse_reg[CMD_HOME];
  assign horizontal_offset = pulse_reg[CMD_HOFF];
  assign scan_offset_move  = pulse_reg[CMD_SCAN_OFS];
  assign scan_move         = pulse_reg[CMD_SCAN];
  assign magnet_en         = magnet_reg;
  assign fault             = (state_reg == ST_FAULT);
  assign cmd_ready         = !fifo_full && (state_reg != ST_FAULT);
  assign busy              = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a motor_main model and a pulse
// scoreboard checked by an independent monitor.
module tb_move_sequencer;
  import move_sequencer_pkg::*;

  localparam int DEPTH   = 16;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_code = 4'd0;
  logic       cmd_magnet = 1'b0;
  logic       clear_fault = 1'b0;
  logic       movement_done = 1'b0;
  logic       reset_done = 1'b0;
  logic       offset_done = 1'b0;
  logic       cmd_ready;
  logic [7:0] direction;
  logic       scan_offset_move, scan_move, horizontal_offset, home;
  logic       magnet_en, busy, fault;
  logic [4:0] fifo_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulse_n = 0;
  int last_pulse_cyc = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_pv, mon_exp;

  int   model_mode = 0;   // 0: answers with done, 1: never answers
  bit   spur_en = 0;      // raise a stray movement_done during HOME
  bit   m_act = 0;
  int   m_k = 0;
  logic m_home = 1'b0, m_hoff = 1'b0;
  logic [11:0] m_pv;

  move_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_code          (cmd_code),
    .cmd_magnet        (cmd_magnet),
    .clear_fault       (clear_fault),
    .direction         (direction),
    .scan_offset_move  (scan_offset_move),
    .scan_move         (scan_move),
    .horizontal_offset (horizontal_offset),
    .home              (home),
    .movement_done     (movement_done),
    .reset_done        (reset_done),
    .offset_done       (offset_done),
    .magnet_en         (magnet_en),
    .busy              (busy),
    .fault             (fault),
    .fifo_count        (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // motor_main model: done 10 cycles after the pulse, dropped 2 cycles later.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_act = 0;
      m_k = 0;
      movement_done = 1'b0;
      reset_done = 1'b0;
      offset_done = 1'b0;
    end else begin
      m_pv = {scan_move, scan_offset_move, horizontal_offset, home, direction};
      if (m_pv != 12'd0) begin
        m_act = 1;
        m_k = 0;
        m_home = home;
        m_hoff = horizontal_offset;
      end else if (m_act) begin
        m_k++;
        if (model_mode == 0 && (m_k == 10 || m_k == 12)) begin
          if (m_home)      reset_done = (m_k == 10);
          else if (m_hoff) offset_done = (m_k == 10);
          else             movement_done = (m_k == 10);
          if (m_k == 12) m_act = 0;
        end
        if (spur_en && m_home && m_k == 3) movement_done = 1'b1;
        if (spur_en && m_home && m_k == 4) movement_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every request pulse must match the next expected one.
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      mon_pv = {scan_move, scan_offset_move, horizontal_offset, home, direction};
      if (mon_pv != 12'd0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse act=%03h req=none cyc=%0d", mon_pv, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_pv !== mon_exp) begin
            bad++;
            $display("FAIL pulse act=%03h req=%03h cyc=%0d", mon_pv, mon_exp, cyc);
          end else
            $display("pulse %03h at cyc %0d", mon_pv, cyc);
        end
        last_pulse_cyc = cyc;
        pulse_n++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  // Offer one command for one cycle; pop_c is the first cycle it sits in the queue.
  task automatic push(input logic [3:0] code, input logic mag, input bit expect_pulse,
                      output bit acc, output int pop_c);
    cmd_code = code;
    cmd_magnet = mag;
    cmd_valid = 1'b1;
    acc = cmd_ready;
    if (acc && expect_pulse)
      exp_q.push_back(12'd1 << code);
    @(posedge clk);
    #1;
    pop_c = cyc;
    $display("push code=%0d mag=%0d acc=%0d cyc=%0d", code, mag, acc, pop_c);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pulse(output int pc);
    int n0;
    int k;
    n0 = pulse_n;
    k = 0;
    while (pulse_n == n0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (pulse_n == n0) begin
      total++;
      bad++;
      $display("FAIL pulse_timeout act=none req=pulse cyc=%0d", cyc);
      pc = -1000;
    end else
      pc = last_pulse_cyc;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int pop_c, pc, pc2, pc3, dummy;
    bit acc;

    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_magnet", magnet_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_pulses", {scan_move, scan_offset_move, horizontal_offset, home, direction}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single move, no magnet change
    push(CMD_N, 1'b0, 1, acc, pop_c);
    wait_pulse(pc);
    chk("t1_latency", pc - pop_c, 2);
    wait_until(pc + 12);
    chk("t1_busy_hold", busy, 1);
    @(negedge clk);
    chk("t1_busy_drop", busy, 0);

    // Magnet on with settle, then back-to-back move without settle
    push(CMD_E, 1'b1, 1, acc, pop_c);
    push(CMD_SE, 1'b1, 1, acc, dummy);
    chk("t2_magnet_on", magnet_en, 1);
    wait_pulse(pc);
    chk("t2_settle_latency", pc - pop_c, SETTLE + 2);
    wait_pulse(pc2);
    chk("t2_back_to_back", pc2 - pc, 15);
    wait_until(pc2 + 13);
    chk("t2_idle", busy, 0);

    // Stuck move fills the queue
    model_mode = 1;
    push(CMD_N, 1'b1, 1, acc, pop_c);
    wait_pulse(pc);
    chk("t3_latency", pc - pop_c, 2);
    for (int i = 0; i < 17; i++) begin
      push(CMD_E, 1'b1, 0, acc, dummy);
      chk("t3_accept", acc, (i < DEPTH) ? 1 : 0);
      chk("t3_count", fifo_count, (i < DEPTH) ? i + 1 : DEPTH);
    end
    chk("t3_ready_full", cmd_ready, 0);

    // Timeout to fault, then clear
    wait_until(pc + TIMEOUT - 1);
    chk("t4_no_early_fault", fault, 0);
    @(negedge clk);
    chk("t4_fault", fault, 1);
    chk("t4_magnet_off", magnet_en, 0);
    chk("t4_flushed", fifo_count, 0);
    chk("t4_ready_low", cmd_ready, 0);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    chk("t4_cleared", fault, 0);
    chk("t4_ready", cmd_ready, 1);
    chk("t4_idle", busy, 0);
    model_mode = 0;

    // HOME drops the magnet and completes only on reset_done
    spur_en = 1;
    push(CMD_E, 1'b1, 1, acc, pop_c);
    push(CMD_HOME, 1'b1, 1, acc, dummy);
    push(CMD_N, 1'b0, 1, acc, dummy);
    wait_pulse(pc);
    chk("t5_e_latency", pc - pop_c, SETTLE + 2);
    wait_pulse(pc2);
    chk("t5_home_gap", pc2 - pc, 13 + SETTLE + 2);
    chk("t5_home_magnet", magnet_en, 0);
    wait_pulse(pc3);
    chk("t5_n_after_reset_done", pc3 - pc2, 15);
    wait_until(pc3 + 13);
    spur_en = 0;
    chk("t5_idle", busy, 0);

    // Reset asserted while waiting for done
    model_mode = 1;
    push(CMD_E, 1'b1, 1, acc, pop_c);
    wait_pulse(pc);
    push(CMD_E, 1'b1, 0, acc, dummy);
    push(CMD_W, 1'b1, 0, acc, dummy);
    chk("t6_queued", fifo_count, 2);
    chk("t6_magnet_before", magnet_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_magnet", magnet_en, 0);
    chk("t6_rst_pulses", {scan_move, scan_offset_move, horizontal_offset, home, direction}, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_fault", fault, 0);
    chk("t6_rst_ready", cmd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_mode = 0;
    @(negedge clk);
    chk("t6_post_count", fifo_count, 0);
    chk("t6_post_busy", busy, 0);
    push(CMD_N, 1'b0, 1, acc, pop_c);
    wait_pulse(pc);
    chk("t6_post_latency", pc - pop_c, 2);
    wait_until(pc + 13);
    chk("t6_post_idle", busy, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
